// File: rtl/enet_dma_pkg.sv
// enet_dma_pkg: shared types and helpers for the Ethernet-to-DDR DMA.
//   rx_state_t / tx_state_t : engine state encodings
//   calc_ratio / calc_eb / calc_db : width-derived constants
//   be_mask : byte count -> low-order-first byte-enable mask
package enet_dma_pkg;

    localparam int unsigned MAX_DB = 128;

    typedef enum logic [1:0] {R_IDLE, R_FILL, R_WRITE, R_DONE} rx_state_t;
    typedef enum logic [2:0] {T_IDLE, T_REQ, T_WAIT, T_DRAIN, T_DONE} tx_state_t;

    function automatic int unsigned calc_ratio(input int unsigned enet_w, input int unsigned ddr_w);
        return ddr_w / enet_w;
    endfunction

    function automatic int unsigned calc_eb(input int unsigned enet_w);
        return enet_w / 8;
    endfunction

    function automatic int unsigned calc_db(input int unsigned ddr_w);
        return ddr_w / 8;
    endfunction

    // Callers truncate the result to their own DB width.
    function automatic logic [MAX_DB-1:0] be_mask(input int unsigned nbytes);
        logic [MAX_DB-1:0] m;
        if (nbytes >= MAX_DB) m = '1;
        else                  m = ~({MAX_DB{1'b1}} << nbytes);
        return m;
    endfunction

endpackage

// File: rtl/enet_ddr_dma_if.sv
// enet_ddr_dma_if: MAC-side streams and DDR write/read channels of the DMA.
//   rx_*  : MAC receive stream into the DMA (valid/ready)
//   tx_*  : MAC transmit stream out of the DMA (valid/ready)
//   wr_*  : DDR write request channel (req held until ack)
//   rd_*  : DDR read request channel plus returned data
// Modports: master = DMA side, slave = MAC/DDR side.
interface enet_ddr_dma_if #(
    parameter int unsigned ENET_W = 64,
    parameter int unsigned DDR_W  = 256,
    parameter int unsigned ADDR_W = 32
);
    logic [ENET_W-1:0]  rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic [ENET_W-1:0]  tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               wr_req;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DDR_W-1:0]   wr_data;
    logic [DDR_W/8-1:0] wr_be;
    logic               wr_ack;
    logic               rd_req;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_ack;
    logic [DDR_W-1:0]   rd_data;
    logic               rd_data_valid;

    modport master (
        input  rx_data, rx_valid, tx_ready, wr_ack, rd_ack, rd_data, rd_data_valid,
        output rx_ready, tx_data, tx_valid, wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, wr_ack, rd_ack, rd_data, rd_data_valid,
        input  rx_ready, tx_data, tx_valid, wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr
    );
endinterface

// File: rtl/enet_dma_perf_cnt.sv
// enet_dma_perf_cnt: 32-bit saturating cycle counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (wins over inc)
//   inc        : count this cycle
//   cnt        : current count, sticks at all-ones
module enet_dma_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt <= '0;
        else if (clr)               cnt <= '0;
        else if (inc && cnt != '1)  cnt <= cnt + 32'd1;
    end
endmodule

// File: rtl/enet_ddr_dma.sv
// enet_ddr_dma: packs the MAC receive stream into DDR write bursts (RX engine)
// and unpacks DDR reads into the MAC transmit stream (TX engine).
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_enable                  : rising edge starts both engines, low aborts
//   i_src_addr / i_dst_addr   : TX source / RX destination byte address
//   i_snd_size / i_rcv_size   : TX / RX byte counts
//   o_tx_cnt / o_rx_cnt       : active-cycle counters
//   o_tx_done / o_rx_done     : sticky completion flags
//   bus                       : MAC streams and DDR channels (master side)
module enet_ddr_dma
    import enet_dma_pkg::*;
#(
    parameter int unsigned ENET_W = 64,
    parameter int unsigned DDR_W  = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic [ADDR_W-1:0] i_src_addr,
    input  logic [ADDR_W-1:0] i_dst_addr,
    input  logic [31:0]       i_snd_size,
    input  logic [31:0]       i_rcv_size,
    output logic [31:0]       o_tx_cnt,
    output logic [31:0]       o_rx_cnt,
    output logic              o_tx_done,
    output logic              o_rx_done,
    enet_ddr_dma_if.master    bus
);
    localparam int unsigned RATIO = calc_ratio(ENET_W, DDR_W);
    localparam int unsigned EB    = calc_eb(ENET_W);
    localparam int unsigned DB    = calc_db(DDR_W);
    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [31:0]       EB32     = 32'(EB);
    localparam logic [ADDR_W-1:0] DB_A     = ADDR_W'(DB);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(RATIO - 1);

    logic              en_q, start;
    rx_state_t         rx_state;
    tx_state_t         tx_state;
    logic [ADDR_W-1:0] dst_addr, src_addr;
    logic [31:0]       rx_rem, tx_rem;
    logic [DDR_W-1:0]  rx_buf, rx_merged, tx_shreg;
    logic [IDX_W-1:0]  rx_idx, tx_idx;
    logic [DB-1:0]     rx_be;
    logic              rx_active, tx_active;

    assign start     = i_enable & ~en_q;
    assign rx_active = (rx_state == R_FILL) || (rx_state == R_WRITE);
    assign tx_active = (tx_state != T_IDLE) && (tx_state != T_DONE);

    assign bus.wr_addr = dst_addr;
    assign bus.rd_addr = src_addr;
    assign bus.tx_data = tx_shreg[ENET_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) en_q <= 1'b0;
        else          en_q <= i_enable;
    end

    // Unfilled lanes of rx_buf are always zero, so OR-in places the word.
    always_comb begin
        rx_merged = rx_buf | (DDR_W'(bus.rx_data) << (32'(rx_idx) * ENET_W));
        rx_be     = DB'(be_mask((32'(rx_idx) + 32'd1) * EB));
    end

    // RX engine: fill one DDR word from the MAC stream, then write it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_state     <= R_IDLE;
            dst_addr     <= '0;
            rx_rem       <= '0;
            rx_buf       <= '0;
            rx_idx       <= '0;
            bus.rx_ready <= 1'b0;
            bus.wr_req   <= 1'b0;
            bus.wr_data  <= '0;
            bus.wr_be    <= '0;
            o_rx_done    <= 1'b0;
        end else begin
            case (rx_state)
                R_IDLE, R_DONE: if (start) begin
                    dst_addr <= i_dst_addr;
                    rx_rem   <= i_rcv_size;
                    rx_buf   <= '0;
                    rx_idx   <= '0;
                    if (i_rcv_size == '0) begin
                        rx_state  <= R_DONE;
                        o_rx_done <= 1'b1;
                    end else begin
                        rx_state     <= R_FILL;
                        o_rx_done    <= 1'b0;
                        bus.rx_ready <= 1'b1;
                    end
                end
                R_FILL: begin
                    if (!i_enable) begin
                        bus.rx_ready <= 1'b0;
                        rx_state     <= R_IDLE;
                    end else if (bus.rx_valid && bus.rx_ready) begin
                        rx_rem <= rx_rem - EB32;
                        if (rx_idx == LAST_IDX || rx_rem == EB32) begin
                            bus.rx_ready <= 1'b0;
                            bus.wr_req   <= 1'b1;
                            bus.wr_data  <= rx_merged;
                            bus.wr_be    <= rx_be;
                            rx_state     <= R_WRITE;
                        end else begin
                            rx_buf <= rx_merged;
                            rx_idx <= rx_idx + IDX_W'(1);
                        end
                    end
                end
                R_WRITE: if (bus.wr_ack) begin
                    // An abort only takes effect once the pending write is acked.
                    bus.wr_req <= 1'b0;
                    dst_addr   <= dst_addr + DB_A;
                    rx_buf     <= '0;
                    rx_idx     <= '0;
                    if (!i_enable) begin
                        rx_state <= R_IDLE;
                    end else if (rx_rem == '0) begin
                        rx_state  <= R_DONE;
                        o_rx_done <= 1'b1;
                    end else begin
                        rx_state     <= R_FILL;
                        bus.rx_ready <= 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // TX engine: one outstanding DDR read, drained low-order word first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state     <= T_IDLE;
            src_addr     <= '0;
            tx_rem       <= '0;
            tx_shreg     <= '0;
            tx_idx       <= '0;
            bus.tx_valid <= 1'b0;
            bus.rd_req   <= 1'b0;
            o_tx_done    <= 1'b0;
        end else begin
            case (tx_state)
                T_IDLE, T_DONE: if (start) begin
                    src_addr <= i_src_addr;
                    tx_rem   <= i_snd_size;
                    tx_idx   <= '0;
                    if (i_snd_size == '0) begin
                        tx_state  <= T_DONE;
                        o_tx_done <= 1'b1;
                    end else begin
                        tx_state   <= T_REQ;
                        o_tx_done  <= 1'b0;
                        bus.rd_req <= 1'b1;
                    end
                end
                T_REQ: if (bus.rd_ack) begin
                    bus.rd_req <= 1'b0;
                    tx_state   <= T_WAIT;
                end
                T_WAIT: if (bus.rd_data_valid) begin
                    // Data of a read issued before an abort is swallowed here.
                    if (!i_enable) begin
                        tx_state <= T_IDLE;
                    end else begin
                        tx_shreg     <= bus.rd_data;
                        tx_idx       <= '0;
                        bus.tx_valid <= 1'b1;
                        tx_state     <= T_DRAIN;
                    end
                end
                T_DRAIN: begin
                    if (!i_enable) begin
                        bus.tx_valid <= 1'b0;
                        tx_state     <= T_IDLE;
                    end else if (bus.tx_valid && bus.tx_ready) begin
                        tx_rem <= tx_rem - EB32;
                        if (tx_idx == LAST_IDX || tx_rem == EB32) begin
                            bus.tx_valid <= 1'b0;
                            if (tx_rem == EB32) begin
                                tx_state  <= T_DONE;
                                o_tx_done <= 1'b1;
                            end else begin
                                tx_state   <= T_REQ;
                                src_addr   <= src_addr + DB_A;
                                bus.rd_req <= 1'b1;
                            end
                        end else begin
                            tx_shreg <= tx_shreg >> ENET_W;
                            tx_idx   <= tx_idx + IDX_W'(1);
                        end
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    enet_dma_perf_cnt u_rx_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (start & ~rx_active),
        .inc   (rx_active),
        .cnt   (o_rx_cnt)
    );

    enet_dma_perf_cnt u_tx_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (start & ~tx_active),
        .inc   (tx_active),
        .cnt   (o_tx_cnt)
    );

endmodule

// File: tb/tb_enet_ddr_dma.sv
// tb_enet_ddr_dma: scoreboard bench for enet_ddr_dma. Expected DDR writes and
// MAC transmit words are queued when a transfer is set up; independent
// responder/monitor processes pop and compare as the DUT presents them.
module tb_enet_ddr_dma;
    localparam int unsigned ENET_W = 64;
    localparam int unsigned DDR_W  = 256;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned RATIO  = DDR_W / ENET_W;
    localparam int unsigned EB     = ENET_W / 8;
    localparam int unsigned DB     = DDR_W / 8;

    typedef struct packed {
        logic [31:0]      addr;
        logic [DDR_W-1:0] data;
        logic [DB-1:0]    be;
    } wr_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0, snd_size = '0, rcv_size = '0;
    logic [31:0] tx_cnt, rx_cnt;
    logic        tx_done, rx_done;

    enet_ddr_dma_if #(.ENET_W(ENET_W), .DDR_W(DDR_W), .ADDR_W(ADDR_W)) bus ();

    enet_ddr_dma #(.ENET_W(ENET_W), .DDR_W(DDR_W), .ADDR_W(ADDR_W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (enable),
        .i_src_addr (src_addr),
        .i_dst_addr (dst_addr),
        .i_snd_size (snd_size),
        .i_rcv_size (rcv_size),
        .o_tx_cnt   (tx_cnt),
        .o_rx_cnt   (rx_cnt),
        .o_tx_done  (tx_done),
        .o_rx_done  (rx_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic [ENET_W-1:0] rx_words[$];
    wr_t               exp_wr[$];
    logic [ENET_W-1:0] exp_tx[$];
    logic [DDR_W-1:0]  mem[logic [31:0]];

    int rx_valid_pct = 100, tx_ready_pct = 100, wr_ack_pct = 100;
    int rd_ack_dly = -1, rd_dat_dly = -1;
    bit hold_wr = 1'b0;
    int n_wr_acks = 0, n_rd_acks = 0;
    int unsigned last_wr_cyc = 0, last_tx_cyc = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [ENET_W-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    // MAC receive source
    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        forever begin
            @(negedge clk);
            if (rx_words.size() > 0 && $urandom_range(99) < rx_valid_pct) begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = rx_words[0];
                if (bus.rx_ready) void'(rx_words.pop_front());
            end else begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = '0;
            end
        end
    end

    // DDR write responder and write scoreboard
    initial begin
        wr_t w;
        bus.wr_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.wr_ack = 1'b0;
            if (bus.wr_req && !hold_wr && $urandom_range(99) < wr_ack_pct) begin
                bus.wr_ack = 1'b1;
                n_wr_acks++;
                last_wr_cyc = cyc;
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got write to %h expected none", bus.wr_addr);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", bus.wr_addr, w.addr);
                    check("wr_data", bus.wr_data, w.data);
                    check("wr_be", bus.wr_be, w.be);
                end
            end
        end
    end

    // DDR read responder backed by mem
    initial begin
        logic [31:0] a;
        int d;
        bus.rd_ack        = 1'b0;
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
        forever begin
            @(negedge clk);
            bus.rd_data_valid = 1'b0;
            if (bus.rd_req) begin
                a = bus.rd_addr;
                d = (rd_ack_dly >= 0) ? rd_ack_dly : int'($urandom_range(0, 4));
                repeat (d) @(negedge clk);
                bus.rd_ack = 1'b1;
                n_rd_acks++;
                @(negedge clk);
                bus.rd_ack = 1'b0;
                d = (rd_dat_dly >= 1) ? rd_dat_dly - 1 : int'($urandom_range(0, 3));
                repeat (d) @(negedge clk);
                bus.rd_data       = mem.exists(a) ? mem[a] : '0;
                bus.rd_data_valid = 1'b1;
            end
        end
    end

    // MAC transmit sink and word scoreboard
    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.tx_ready = ($urandom_range(99) < tx_ready_pct);
            if (bus.tx_valid && bus.tx_ready) begin
                last_tx_cyc = cyc;
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got word %h expected none", bus.tx_data);
                end else begin
                    check("tx_data", bus.tx_data, exp_tx.pop_front());
                end
            end
        end
    end

    task automatic flush();
        rx_words.delete();
        exp_wr.delete();
        exp_tx.delete();
    endtask

    // Reference: RX word i lands in DDR word i/RATIO, lane i%RATIO; TX is the reverse.
    task automatic setup(input logic [31:0] s_addr, input logic [31:0] d_addr,
                         input logic [31:0] s_size, input logic [31:0] r_size, input int extra);
        int unsigned nrx = r_size / EB;
        int unsigned ntx = s_size / EB;
        wr_t w;
        logic [ENET_W-1:0] word;
        logic [DDR_W-1:0]  line;
        flush();
        for (int unsigned j = 0; j < (nrx + RATIO - 1) / RATIO; j++) begin
            w.addr = d_addr + j * DB;
            w.data = '0;
            w.be   = '0;
            for (int unsigned k = 0; k < RATIO; k++) begin
                if (j * RATIO + k < nrx) begin
                    word = rand_word();
                    rx_words.push_back(word);
                    w.data[k*ENET_W +: ENET_W] = word;
                    w.be[k*EB +: EB] = '1;
                end
            end
            exp_wr.push_back(w);
        end
        for (int e = 0; e < extra; e++) rx_words.push_back(rand_word());
        for (int unsigned j = 0; j < (ntx + RATIO - 1) / RATIO; j++) begin
            for (int unsigned k = 0; k < RATIO; k++) line[k*ENET_W +: ENET_W] = rand_word();
            mem[s_addr + j * DB] = line;
            for (int unsigned k = 0; k < RATIO; k++)
                if (j * RATIO + k < ntx) exp_tx.push_back(line[k*ENET_W +: ENET_W]);
        end
        src_addr  = s_addr;
        dst_addr  = d_addr;
        snd_size  = s_size;
        rcv_size  = r_size;
        n_wr_acks = 0;
        n_rd_acks = 0;
    endtask

    task automatic run_xfer(input logic [31:0] s_addr, input logic [31:0] d_addr,
                            input logic [31:0] s_size, input logic [31:0] r_size, input int extra);
        int rx_act = 0, tx_act = 0, t = 0;
        bit rx_seen = 1'b0, tx_seen = 1'b0;
        int unsigned rx_dc = 0, tx_dc = 0;
        setup(s_addr, d_addr, s_size, r_size, extra);
        @(negedge clk);
        enable = 1'b1;
        while (!(rx_seen && tx_seen) && t < 4000) begin
            @(negedge clk);
            t++;
            if (!rx_seen) begin
                if (rx_done) begin rx_seen = 1'b1; rx_dc = cyc; end
                else rx_act++;
            end
            if (!tx_seen) begin
                if (tx_done) begin tx_seen = 1'b1; tx_dc = cyc; end
                else tx_act++;
            end
        end
        check("rx_done_reached", rx_seen, 1'b1);
        check("tx_done_reached", tx_seen, 1'b1);
        check("rx_cnt", rx_cnt, rx_act);
        check("tx_cnt", tx_cnt, tx_act);
        check("wr_count", n_wr_acks, (r_size + DB - 1) / DB);
        check("rd_count", n_rd_acks, (s_size + DB - 1) / DB);
        check("wr_left", exp_wr.size(), 0);
        check("tx_left", exp_tx.size(), 0);
        check("rx_words_left", rx_words.size(), extra);
        if (r_size == 0) check("rx_zero_latency", rx_act, 0);
        else             check("rx_done_timing", rx_dc, last_wr_cyc + 1);
        if (s_size == 0) check("tx_zero_latency", tx_act, 0);
        else             check("tx_done_timing", tx_dc, last_tx_cyc + 1);
        @(negedge clk);
        enable = 1'b0;
    endtask

    initial begin
        int t;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_flags", {rx_done, tx_done, bus.rx_ready, bus.tx_valid, bus.wr_req, bus.rd_req}, '0);
        check("rst_cnts", {rx_cnt, tx_cnt}, '0);
        check("rst_addrs", {bus.wr_addr, bus.rd_addr, bus.tx_data}, '0);
        check("rst_wr", {bus.wr_data, bus.wr_be}, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two full writes with all bytes enabled
        run_xfer(32'h0000_1000, 32'h0000_2000, 0, 64, 0);
        // Partial final write; the word after the last must stay unrequested
        run_xfer(32'h0000_1000, 32'h0000_2400, 0, 40, 1);
        // Fixed read latency with the sink always ready
        rd_ack_dly = 5; rd_dat_dly = 3;
        run_xfer(32'h0000_4000, 32'h0, 32, 0, 0);
        rd_ack_dly = -1; rd_dat_dly = -1;
        // Both engines together under transmit backpressure
        tx_ready_pct = 50; rx_valid_pct = 60; wr_ack_pct = 50;
        run_xfer(32'h0000_8000, 32'h0000_9000, 256, 128, 0);
        // Zero sizes
        run_xfer(32'h0000_8000, 32'h0000_9000, 0, 0, 0);
        // Destination and source wrapping past the top of the address space
        run_xfer(32'hFFFF_FFE0, 32'hFFFF_FFE0, 72, 72, 0);
        for (int i = 0; i < 6; i++) begin
            rx_valid_pct = 30 + $urandom_range(70);
            tx_ready_pct = 30 + $urandom_range(70);
            wr_ack_pct   = 30 + $urandom_range(70);
            run_xfer({$urandom} & ~32'(DB - 1), {$urandom} & ~32'(DB - 1),
                     EB * $urandom_range(0, 24), EB * $urandom_range(0, 24),
                     int'($urandom_range(0, 2)));
        end

        // Abort with a write pending
        rx_valid_pct = 100; tx_ready_pct = 100; wr_ack_pct = 100;
        hold_wr = 1'b1;
        setup(32'h0, 32'h0000_3000, 0, 64, 0);
        @(negedge clk);
        enable = 1'b1;
        t = 0;
        while (!bus.wr_req && t < 200) begin @(negedge clk); t++; end
        check("abort_wr_req_seen", bus.wr_req, 1'b1);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_req_held", bus.wr_req, 1'b1);
        hold_wr = 1'b0;
        t = 0;
        while (n_wr_acks == 0 && t < 100) begin @(negedge clk); t++; end
        check("abort_acked", n_wr_acks, 1);
        repeat (3) @(negedge clk);
        check("abort_idle", {rx_done, bus.wr_req, bus.rx_ready}, '0);
        run_xfer(32'h0, 32'h0000_3000, 0, 64, 0);

        // Asynchronous reset in the middle of a drain
        tx_ready_pct = 0;
        setup(32'h0000_5000, 32'h0, 64, 0, 0);
        @(negedge clk);
        enable = 1'b1;
        t = 0;
        while (!bus.tx_valid && t < 200) begin @(negedge clk); t++; end
        check("drain_valid_seen", bus.tx_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_flags", {rx_done, tx_done, bus.rx_ready, bus.tx_valid, bus.wr_req, bus.rd_req}, '0);
        check("arst_cnts", {rx_cnt, tx_cnt}, '0);
        check("arst_addrs", {bus.wr_addr, bus.rd_addr, bus.tx_data}, '0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        flush();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, required completion");
        $fatal(1, "timeout");
    end

endmodule
